reg_mem_arbiter: RTL

- Shares one SRAM-style memory port (req/gnt/we/addr/wdata/wstrb/rdata/rvalid/rerror) between NumPorts register-bus requesters.
- Round-robin arbitration, at most one transaction in flight at a time.
- A winner stays locked until its transaction completes, so register-bus request stability holds.
- Sits between the peripheral register-bus demux and a single-ported scratch/config SRAM.

---
 rtl/reg_mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/reg_mem_arbiter.sv
// Round-robin arbiter sharing one SRAM port between register-bus requesters.
// Optional read-timeout with a response-drain state: define REG_MEM_ARBITER_TIMEOUT_EN.
package reg_mem_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;
endpackage

// state     | meaning
// IDLE      | scanning requesters, single-cycle writes complete here
// LOCK      | winner frozen, waiting for SRAM grant
// READ_WAIT | read granted, waiting for rvalid
// DRAIN     | read timed out, swallowing the late rvalid (timeout build only)
module reg_mem_arbiter #(
  parameter int NumPorts      = 2,
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int TimeoutCycles = 255,
  parameter type req_t        = reg_mem_arbiter_pkg::reg_req_t,
  parameter type rsp_t        = reg_mem_arbiter_pkg::reg_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  req_t  [NumPorts-1:0] reg_req_i,
  output rsp_t  [NumPorts-1:0] reg_rsp_o,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 we_o,
  output logic [AW-1:0]        addr_o,
  output logic [DW-1:0]        wdata_o,
  output logic [DW/8-1:0]      wstrb_o,
  input  logic [DW-1:0]        rdata_i,
  input  logic                 rvalid_i,
  input  logic                 rerror_i
);

  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int SW = DW / 8;

`ifdef REG_MEM_ARBITER_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, LOCK, READ_WAIT, DRAIN} state_e;
  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TimeoutCycles);
  logic [CW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE, LOCK, READ_WAIT} state_e;
`endif

  state_e        state_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] rr_q;
  logic [PW-1:0] winner;
  logic [PW-1:0] sel;
  logic          any_valid;
  logic          sel_write;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    if (NumPorts == 1 || int'(p) >= NumPorts - 1) return '0;
    return p + PW'(1);
  endfunction

  // Reverse scan so the last hit is the first port in round-robin order.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_valid = 1'b0;
    winner    = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % NumPorts;
      if (reg_req_i[idx].valid) begin
        any_valid = 1'b1;
        winner    = PW'(idx);
      end
    end
  end

  assign sel       = (state_q == IDLE) ? winner : owner_q;
  assign sel_write = reg_req_i[sel].write;
  assign we_o      = reg_req_i[sel].write;
  assign addr_o    = AW'(reg_req_i[sel].addr);
  assign wdata_o   = DW'(reg_req_i[sel].wdata);
  assign wstrb_o   = SW'(reg_req_i[sel].wstrb);

  // Gating with rst_ni makes req_o and ready drop as soon as reset asserts.
  always_comb begin
    req_o = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      reg_rsp_o[i]       = '0;
      reg_rsp_o[i].rdata = rdata_i;
    end
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          req_o = any_valid;
          if (any_valid && gnt_i && sel_write) begin
            reg_rsp_o[winner].ready = 1'b1;
            reg_rsp_o[winner].error = rerror_i;
          end
        end
        LOCK: begin
          req_o = 1'b1;
          if (gnt_i && sel_write) begin
            reg_rsp_o[owner_q].ready = 1'b1;
            reg_rsp_o[owner_q].error = rerror_i;
          end
        end
        READ_WAIT: begin
          if (rvalid_i) begin
            reg_rsp_o[owner_q].ready = 1'b1;
            reg_rsp_o[owner_q].error = rerror_i;
          end
`ifdef REG_MEM_ARBITER_TIMEOUT_EN
          else if (cnt_q == TO_MAX) begin
            reg_rsp_o[owner_q].ready = 1'b1;
            reg_rsp_o[owner_q].error = 1'b1;
            reg_rsp_o[owner_q].rdata = '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
`ifdef REG_MEM_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            if (gnt_i && sel_write) begin
              rr_q <= next_port(winner);
            end else if (gnt_i) begin
              owner_q <= winner;
              state_q <= READ_WAIT;
`ifdef REG_MEM_ARBITER_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              owner_q <= winner;
              state_q <= LOCK;
            end
          end
        end
        LOCK: begin
          if (gnt_i && sel_write) begin
            rr_q    <= next_port(owner_q);
            state_q <= IDLE;
          end else if (gnt_i) begin
            state_q <= READ_WAIT;
`ifdef REG_MEM_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        READ_WAIT: begin
          if (rvalid_i) begin
            rr_q    <= next_port(owner_q);
            state_q <= IDLE;
          end
`ifdef REG_MEM_ARBITER_TIMEOUT_EN
          else if (cnt_q == TO_MAX) begin
            rr_q    <= next_port(owner_q);
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
`ifdef REG_MEM_ARBITER_TIMEOUT_EN
        DRAIN: begin
          if (rvalid_i) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
